fp_div: RTL and testbench
=========================

# fp_div

Sequential IEEE-754-format floating-point divider, the inverse of the combinational `fp_mul` datapath. It computes OUT = IN1 / IN2 with an iterative restoring mantissa divider that retires one quotient bit per cycle, behind valid/ready handshakes on both sides. It shares `fp_mul`'s number model: implicit leading 1 always, no special-value detection, and modular exponent arithmetic. It sits beside `fp_mul` in the arithmetic cluster as the low-area division unit.

## Interface
- FP_WIDTH, 32, total word width
- EXP_WIDTH, 8, exponent field width
- MAN_WIDTH, 23, stored mantissa field width (no hidden bit)

- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  asynchronous, active-high reset
- IN_VALID  input  1  operand pair offered
- IN_READY  output  1  divider idle, can accept operands
- IN1  input  FP_WIDTH  dividend
- IN2  input  FP_WIDTH  divisor
- OUT_VALID  output  1  result held on OUT
- OUT_READY  input  1  consumer accepts result
- OUT  output  FP_WIDTH  quotient {sign, exponent, mantissa}

## Operation
- States:
  - IDLE: IN_READY=1.
  - DIV: iterating.
  - DONE: OUT_VALID=1.
- IDLE → DIV on IN_VALID && IN_READY. Latch:
  - sign = IN1[FP_WIDTH-1] ^ IN2[FP_WIDTH-1].
  - M1 = {1, IN1 mantissa} and D = {1, IN2 mantissa}.
  - Pre-normalize: if M1 < D, remainder R = M1<<1 and adj = 1. Otherwise R = M1 and adj = 0.
  - Exponent: E = E1 − E2 + (2^(EXP_WIDTH−1) − 1) − adj, computed modulo 2^EXP_WIDTH. Overflow and underflow wrap silently.
- DIV: N = MAN_WIDTH+2 iterations, counted by a down-counter.
  - Each iteration: if R ≥ D, R ← (R−D)<<1 and q bit = 1. Otherwise R ← R<<1 and q bit = 0.
  - q bits shift into a quotient register Q[MAN_WIDTH+1:0], MSB first.
  - R is MAN_WIDTH+3 bits wide.
  - Q[MAN_WIDTH+1] is always 1. Q[MAN_WIDTH:1] is the mantissa and Q[0] is the guard bit.
- After the Nth iteration, move to DONE and register OUT. OUT stays stable while OUT_VALID=1.
- DONE → IDLE on OUT_READY. OUT_VALID may fall in the same cycle IN_READY rises, but never overlaps it.
- IN_VALID is ignored outside IDLE. IN1 and IN2 are sampled only at the accept edge.
- Zero, denormal, infinity and NaN inputs are treated as normal numbers with a hidden 1, matching `fp_mul`. A zero divisor yields a finite, meaningless result.

## Timing
- Reset values: state=IDLE, IN_READY=1, OUT_VALID=0, OUT=0, counter=0, Q=0, R=0.
- Latency: accept at edge t0; OUT_VALID=1 after edge t0+N (25 cycles for FP32).
- Minimum initiation interval: N+2 cycles.
- OUT_READY held high in DONE: result is consumed one cycle after OUT_VALID rises.
- RST mid-DIV or mid-DONE: immediately abandon the operation, drop OUT_VALID, return to IDLE. No partial result is ever emitted.
- OUT_READY during IDLE or DIV has no effect.

## Configuration
- FP_DIV_RNE_EN defined: round to nearest, ties to even.
  - Sticky = (final R ≠ 0). Increment the mantissa when guard && (sticky || mantissa LSB).
  - Mantissa overflow (all ones + 1) gives mantissa 0 and exponent + 1, modulo 2^EXP_WIDTH.
  - Rounding is done in the DIV→DONE transition and adds no cycles.
- FP_DIV_RNE_EN undefined: truncate. OUT mantissa = Q[MAN_WIDTH:1], and the guard bit and remainder are discarded.
- Latency and handshake are identical in both builds.

## Test plan
- 6.0/2.0: 0x40C00000 / 0x40000000 → OUT=0x40400000. OUT_VALID rises exactly 25 cycles after the accept edge, and IN_READY=0 throughout.
- 1.0/3.0: 0x3F800000 / 0x40400000 (pre-normalize path) → 0x3EAAAAAB with FP_DIV_RNE_EN, 0x3EAAAAAA without.
- −1.5/0.5: 0xBFC00000 / 0x3F000000 → 0xC0400000.
- Backpressure: hold OUT_READY=0 for 10 cycles in DONE → OUT stable, OUT_VALID=1, IN_READY=0, IN_VALID ignored. Raise OUT_READY → IDLE next cycle, and a new op is accepted.
- Reset mid-operation: assert RST at cycle 10 of DIV → OUT_VALID=0 and IN_READY=1 immediately. A following 1.0/1.0 (0x3F800000 / 0x3F800000) then returns 0x3F800000.
- Back-to-back: 20 random normal-range operand pairs with OUT_READY tied high → each OUT matches the reference model for the build's rounding mode, and accepts are spaced N+2 cycles apart.

Source files
------------

// File: rtl/fp_div.sv
// Sequential floating-point divider: restoring mantissa divide, one quotient bit per cycle.
// Define FP_DIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp_div #(
    parameter int FP_WIDTH  = 32,
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [FP_WIDTH-1:0] IN1,
    input  logic [FP_WIDTH-1:0] IN2,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [FP_WIDTH-1:0] OUT
);
    localparam int N  = MAN_WIDTH + 2;
    localparam int CW = $clog2(N + 1);
    localparam int RW = MAN_WIDTH + 3;
    localparam logic [EXP_WIDTH-1:0] BIAS = {1'b0, {(EXP_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [N-1:0]          q;
    logic [RW-1:0]         r;
    logic [MAN_WIDTH:0]    d;
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp_q;
    logic [FP_WIDTH-1:0]   out_q;

    // operand decode at accept
    logic [MAN_WIDTH:0]    m1_in, d_in;
    logic [EXP_WIDTH-1:0]  e1_in, e2_in, exp_in;
    logic                  adj;
    logic [RW-1:0]         r_in;

    assign m1_in  = {1'b1, IN1[MAN_WIDTH-1:0]};
    assign d_in   = {1'b1, IN2[MAN_WIDTH-1:0]};
    assign e1_in  = IN1[FP_WIDTH-2 -: EXP_WIDTH];
    assign e2_in  = IN2[FP_WIDTH-2 -: EXP_WIDTH];
    assign adj    = (m1_in < d_in);
    assign r_in   = adj ? {1'b0, m1_in, 1'b0} : {2'b00, m1_in};
    assign exp_in = e1_in - e2_in + BIAS - {{(EXP_WIDTH-1){1'b0}}, adj};

    // one restoring step; the partial remainder stays below 2*D so the shift never overflows
    logic                  ge;
    logic [RW-1:0]         r_diff, r_nxt;
    logic [N-1:0]          q_nxt;

    assign ge     = (r >= {2'b00, d});
    assign r_diff = ge ? (r - {2'b00, d}) : r;
    assign r_nxt  = r_diff << 1;
    assign q_nxt  = {q[N-2:0], ge};

    logic [MAN_WIDTH-1:0]  man_res;
    logic [EXP_WIDTH-1:0]  exp_res;

`ifdef FP_DIV_RNE_EN
    logic                  guard, sticky, inc;
    logic [MAN_WIDTH:0]    man_sum;

    assign guard   = q_nxt[0];
    assign sticky  = |r_nxt;
    assign inc     = guard & (sticky | q_nxt[1]);
    assign man_sum = {1'b0, q_nxt[MAN_WIDTH:1]} + {{MAN_WIDTH{1'b0}}, inc};
    assign man_res = man_sum[MAN_WIDTH-1:0];
    assign exp_res = exp_q + {{(EXP_WIDTH-1){1'b0}}, man_sum[MAN_WIDTH]};
`else
    assign man_res = q_nxt[MAN_WIDTH:1];
    assign exp_res = exp_q;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (IN_VALID)           state_nxt = DIV;
            DIV:     if (cnt == CW'(1))      state_nxt = DONE;
            DONE:    if (OUT_READY)          state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        IN_READY  = (state == IDLE);
        OUT_VALID = (state == DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            d     <= '0;
            sign  <= 1'b0;
            exp_q <= '0;
            out_q <= '0;
        end else begin
            case (state)
                IDLE: if (IN_VALID) begin
                    cnt   <= CW'(N);
                    q     <= '0;
                    r     <= r_in;
                    d     <= d_in;
                    sign  <= IN1[FP_WIDTH-1] ^ IN2[FP_WIDTH-1];
                    exp_q <= exp_in;
                end
                DIV: begin
                    cnt <= cnt - CW'(1);
                    q   <= q_nxt;
                    r   <= r_nxt;
                    if (cnt == CW'(1))
                        out_q <= {sign, exp_res, man_res};
                end
                default: ;
            endcase
        end
    end

    assign OUT = out_q;
endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: stimulus pushes expected quotients, a monitor pops on each output handshake.
module tb_fp_div;
    localparam int N = 25;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] IN1 = '0;
    logic [31:0] IN2 = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [31:0] OUT;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    time last_acc = 0;

    fp_div #(.FP_WIDTH(32), .EXP_WIDTH(8), .MAN_WIDTH(23)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN1(IN1), .IN2(IN2), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT(OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Quotient as a scaled integer division: (M1<<adj) * 2^24 / D yields the 25-bit Q directly.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        longint unsigned m1, dv, num, qq, rem;
        int adj, e, mant;
        bit guard, sticky;
        m1   = 64'h800000 | 64'(a[22:0]);
        dv   = 64'h800000 | 64'(b[22:0]);
        adj  = (m1 < dv) ? 1 : 0;
        e    = (int'(a[30:23]) - int'(b[30:23]) + 127 - adj) & 255;
        num  = (m1 << adj) << 24;
        qq   = num / dv;
        rem  = num % dv;
        mant = int'((qq >> 1) & 64'h7FFFFF);
        guard  = qq[0];
        sticky = (rem != 0);
`ifdef FP_DIV_RNE_EN
        if (guard && (sticky || mant[0])) begin
            mant = mant + 1;
            if (mant == 32'h800000) begin
                mant = 0;
                e = (e + 1) & 255;
            end
        end
`endif
        return {a[31] ^ b[31], 8'(e), 23'(mant)};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                         input bit chk_ii);
        int w = 0;
        @(negedge CLK);
        while (!IN_READY && w < 200) begin
            @(negedge CLK);
            w++;
        end
        if (!IN_READY) begin
            tests++; fails++;
            $display("FAIL accept_timeout: IN_READY stayed 0 for %0d cycles", w);
            return;
        end
        IN1 = a; IN2 = b; IN_VALID = 1'b1;
        @(posedge CLK);
        exp_q.push_back(expv);
        if (chk_ii) check("init_interval", 32'(($time - last_acc) / 10), 32'(N + 2));
        last_acc = $time;
        #1 IN_VALID = 1'b0;
    endtask

    // waits on posedges (+1) for OUT_VALID; returns cycles waited
    task automatic wait_valid(output int k, output bit rdy_seen);
        k = 0; rdy_seen = 0;
        do begin
            @(posedge CLK); #1;
            k++;
            if (!OUT_VALID && IN_READY) rdy_seen = 1;
        end while (!OUT_VALID && k < 100);
        if (!OUT_VALID) begin
            tests++; fails++;
            $display("FAIL valid_timeout: OUT_VALID 0 after %0d cycles", k);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_output: got 0x%08h with empty scoreboard", OUT);
            end else begin
                check("result", OUT, exp_q.pop_front());
            end
        end
    end

    initial begin
        int k;
        bit rs;
        logic [31:0] held, a, b;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_in_ready", 32'(IN_READY), 32'd1);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_out", OUT, 32'h0);
        RST = 1'b0;

        // 6.0 / 2.0 with latency and busy check
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 0);
        wait_valid(k, rs);
        check("latency", 32'(k), 32'(N));
        check("busy_in_ready", 32'(rs), 32'd0);

        issue(32'h3F800000, 32'h40400000,
`ifdef FP_DIV_RNE_EN
              32'h3EAAAAAB,
`else
              32'h3EAAAAAA,
`endif
              0);
        issue(32'hBFC00000, 32'h3F000000, 32'hC0400000, 0);
        wait_valid(k, rs);

        // backpressure in DONE
        @(posedge CLK); #1 OUT_READY = 1'b0;
        issue(32'h40E00000, 32'h40000000, 32'h40600000, 0);
        wait_valid(k, rs);
        held = OUT;
        IN1 = 32'h3F800000; IN2 = 32'h3F800000; IN_VALID = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            check("bp_out_stable", OUT, held);
            check("bp_out_valid", 32'(OUT_VALID), 32'd1);
            check("bp_in_ready", 32'(IN_READY), 32'd0);
        end
        IN_VALID = 1'b0;
        @(posedge CLK); #1 OUT_READY = 1'b1;
        @(posedge CLK); #1;
        check("bp_release_ready", 32'(IN_READY), 32'd1);
        check("bp_release_valid", 32'(OUT_VALID), 32'd0);
        issue(32'h41200000, 32'h40A00000, 32'h40000000, 0);
        wait_valid(k, rs);

        // reset mid-divide
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 0);
        repeat (10) @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        check("midrst_out_valid", 32'(OUT_VALID), 32'd0);
        check("midrst_in_ready", 32'(IN_READY), 32'd1);
        exp_q.delete();
        @(posedge CLK); #1 RST = 1'b0;
        issue(32'h3F800000, 32'h3F800000, 32'h3F800000, 0);
        wait_valid(k, rs);

        // back-to-back random normal operands
        @(posedge CLK); #1 OUT_READY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
            issue(a, b, model(a, b), i > 0);
        end

        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge CLK);
            k++;
        end
        @(negedge CLK);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
